start_fifo_srl_read_ctrl: RTL and testbench

- Read-side controller and output stage for the SRL start-token FIFOs between dataflow processes in the Linear_Layer i4xi4 kernel.
- Drives the write-enable and read address of an external `*_ShiftReg` storage instance.
- Tracks occupancy and presents the upstream full handshake.
- Prefetches the oldest entry into a registered output with an empty_n/read handshake toward the consuming PE process.

---
 rtl/start_fifo_srl_read_ctrl.sv | 116 +++++++++++
 tb/tb_start_fifo_srl_read_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/start_fifo_srl_read_ctrl.sv
// Read-side controller for an SRL-backed start-token FIFO.
// Owns the occupancy count of an external shift register, drives its write
// enable and read address, and prefetches the oldest entry into a registered
// output stage with an empty_n/read handshake. Total capacity is DEPTH+1.
module start_fifo_srl_read_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  srl_we,
  output logic [DATA_WIDTH-1:0] srl_din,
  output logic [ADDR_WIDTH-1:0] srl_addr,
  input  logic [DATA_WIDTH-1:0] srl_dout
);

  localparam int                CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  out_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_full_n;
  logic                  r_empty_n;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  // A write during reset must never reach the shift register.
  assign w_push = if_write & r_full_n & ~reset;
  assign w_pop  = if_read & r_empty_n;

  // Refill the output register whenever it is free or being popped and the
  // SRL holds something; srl_dout is sampled before this edge's shift.
  assign w_load = (r_cnt != {CNT_W{1'b0}}) & ((r_state == OUT_EMPTY) | w_pop);

  // Push and load together leave cnt unchanged: the shift moves the
  // next-oldest entry into the slot that the address already points at.
  assign w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_load);

  // Oldest entry sits at cnt-1; parked at 0 when the SRL is empty. Modular
  // subtraction on the low bits also covers cnt == 2**ADDR_WIDTH.
  assign w_addr_nxt = (w_cnt_nxt == {CNT_W{1'b0}}) ? {ADDR_WIDTH{1'b0}}
                                                   : (w_cnt_nxt[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1));

  assign srl_we     = w_push;
  assign srl_din    = if_din;
  assign srl_addr   = r_addr;
  assign if_full_n  = r_full_n;
  assign if_empty_n = r_empty_n;
  assign if_dout    = r_dout;

  // Occupancy, handshake flags, SRL address and output-stage FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= OUT_EMPTY;
      r_cnt     <= {CNT_W{1'b0}};
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
      r_dout    <= {DATA_WIDTH{1'b0}};
      r_addr    <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_full_n <= (w_cnt_nxt != DEPTH_C);
      r_addr   <= w_addr_nxt;
      case (r_state)
        OUT_EMPTY: begin
          if (w_load) begin
            r_state   <= OUT_VALID;
            r_empty_n <= 1'b1;
            r_dout    <= srl_dout;
          end else begin
            r_state   <= OUT_EMPTY;
            r_empty_n <= 1'b0;
          end
        end
        OUT_VALID: begin
          if (w_load) begin
            // Back-to-back streaming: pop and refill on the same edge.
            r_state   <= OUT_VALID;
            r_empty_n <= 1'b1;
            r_dout    <= srl_dout;
          end else if (w_pop) begin
            // Drained; if_dout keeps its last value.
            r_state   <= OUT_EMPTY;
            r_empty_n <= 1'b0;
          end else begin
            r_state   <= OUT_VALID;
            r_empty_n <= 1'b1;
          end
        end
        default: begin
          r_state   <= OUT_EMPTY;
          r_empty_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_fifo_srl_read_ctrl.sv
// Directed and randomised bench for start_fifo_srl_read_ctrl, with a
// behavioural shift register standing in for the external SRL storage.
module tb_start_fifo_srl_read_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          if_full_n;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_empty_n;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          srl_we;
  logic [DW-1:0] srl_din;
  logic [AW-1:0] srl_addr;
  logic [DW-1:0] srl_dout;

  logic [DW-1:0] sreg [0:DEPTH-1];

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q [$];

  start_fifo_srl_read_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_full_n  (if_full_n),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_empty_n (if_empty_n),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .srl_we     (srl_we),
    .srl_din    (srl_din),
    .srl_addr   (srl_addr),
    .srl_dout   (srl_dout)
  );

  // Clock generator.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural shift register: newest entry at index 0.
  always_ff @(posedge clk) begin
    if (srl_we) begin
      sreg[0] <= srl_din;
      for (int i = 1; i < DEPTH; i++) sreg[i] <= sreg[i-1];
    end
  end

  assign srl_dout = sreg[srl_addr];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [DW-1:0] din, input logic rd);
    if_write = wr;
    if_din   = din;
    if_read  = rd;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sreg[i] = 8'h00;
    reset    = 1'b1;
    if_write = 1'b0;
    if_din   = 8'h00;
    if_read  = 1'b0;

    // ---------------- reset state ----------------
    tick();
    drive(1'b1, 8'hEE, 1'b1);   // write attempted during reset must be blocked
    chk_eq("rst_srl_we", {31'd0, srl_we}, 32'd0);
    tick();
    chk_eq("rst_full_n", {31'd0, if_full_n}, 32'd1);
    chk_eq("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk_eq("rst_dout", {24'd0, if_dout}, 32'h00);
    chk_eq("rst_addr", {30'd0, srl_addr}, 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk_eq("rst_empty_n2", {31'd0, if_empty_n}, 32'd0);
    reset = 1'b0;

    // ---------------- single write, 2-cycle latency ----------------
    drive(1'b1, 8'hA5, 1'b0);
    chk_eq("single_we", {31'd0, srl_we}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("single_empty_c1", {31'd0, if_empty_n}, 32'd0);
    tick();
    chk_eq("single_empty_c2", {31'd0, if_empty_n}, 32'd1);
    chk_eq("single_dout", {24'd0, if_dout}, 32'hA5);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("single_empty_c3", {31'd0, if_empty_n}, 32'd0);
    chk_eq("single_dout_hold", {24'd0, if_dout}, 32'hA5);

    // ---------------- fill without reads ----------------
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      if (i == 6) begin
        chk_eq("fill_full_n", {31'd0, if_full_n}, 32'd0);
        chk_eq("fill_we_blocked", {31'd0, srl_we}, 32'd0);
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("fill_addr", {30'd0, srl_addr}, 32'd3);
    for (int k = 1; k <= 5; k++) begin
      chk_eq("fill_pop_valid", {31'd0, if_empty_n}, 32'd1);
      chk_eq("fill_pop_data", {24'd0, if_dout}, 32'(k));
      drive(1'b0, 8'h00, 1'b1);
      tick();
      if (k == 1) chk_eq("fill_full_n_back", {31'd0, if_full_n}, 32'd1);
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("fill_drained", {31'd0, if_empty_n}, 32'd0);
    chk_eq("fill_dout_hold", {24'd0, if_dout}, 32'h05);

    // ---------------- continuous streaming ----------------
    for (int c = 0; c < 18; c++) begin
      drive((c < 16) ? 1'b1 : 1'b0, 8'(8'h10 + c), 1'b1);
      if (c >= 2) begin
        chk_eq("stream_valid", {31'd0, if_empty_n}, 32'd1);
        chk_eq("stream_data", {24'd0, if_dout}, 32'(8'h10 + c - 2));
      end
      chk_eq("stream_addr", {30'd0, srl_addr}, 32'd0);
      chk_eq("stream_full_n", {31'd0, if_full_n}, 32'd1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("stream_end_empty", {31'd0, if_empty_n}, 32'd0);

    // ---------------- push + pop at cnt = DEPTH-1 ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h21 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("pp_addr_before", {30'd0, srl_addr}, 32'd2);
    chk_eq("pp_dout_before", {24'd0, if_dout}, 32'h21);
    drive(1'b1, 8'h25, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("pp_addr_after", {30'd0, srl_addr}, 32'd2);
    chk_eq("pp_dout_after", {24'd0, if_dout}, 32'h22);
    chk_eq("pp_full_n", {31'd0, if_full_n}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      tick();
      chk_eq("pp_drain", {24'd0, if_dout}, 32'(8'h23 + k));
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("pp_empty", {31'd0, if_empty_n}, 32'd0);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h31 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("mid_pre_addr", {30'd0, srl_addr}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_eq("mid_empty_n", {31'd0, if_empty_n}, 32'd0);
    chk_eq("mid_full_n", {31'd0, if_full_n}, 32'd1);
    chk_eq("mid_addr", {30'd0, srl_addr}, 32'd0);
    chk_eq("mid_dout", {24'd0, if_dout}, 32'h00);
    drive(1'b1, 8'h77, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk_eq("mid_new_valid", {31'd0, if_empty_n}, 32'd1);
    chk_eq("mid_new_data", {24'd0, if_dout}, 32'h77);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("mid_alone", {31'd0, if_empty_n}, 32'd0);

    // ---------------- randomised traffic against a queue model ----------------
    do_reset();
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic wr;
      logic rd;
      logic acc;
      logic pop;
      if ((c / 500) % 2 == 0) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      drive(wr, 8'($urandom_range(0, 255)), rd);
      acc = if_write & if_full_n;
      pop = if_read & if_empty_n;
      chk_eq("rnd_we", {31'd0, srl_we}, {31'd0, acc});
      if (pop) begin
        chk_eq("rnd_underflow", {31'd0, (q.size() != 0)}, 32'd1);
        if (q.size() != 0) chk_eq("rnd_data", {24'd0, if_dout}, {24'd0, q.pop_front()});
      end
      if (acc) q.push_back(if_din);
      tick();
      chk_eq("rnd_overflow", {31'd0, (q.size() <= DEPTH + 1)}, 32'd1);
      chk_eq("rnd_full_n", {31'd0, if_full_n}, {31'd0, (q.size() <= DEPTH)});
      if (q.size() == 0) chk_eq("rnd_empty", {31'd0, if_empty_n}, 32'd0);
      if (q.size() >= 2) chk_eq("rnd_valid", {31'd0, if_empty_n}, 32'd1);
    end
    // Drain whatever is left, bounded.
    for (int c = 0; c < 4 * DEPTH + 8; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (if_empty_n) begin
        if (q.size() == 0) chk_eq("drain_underflow", 32'd1, 32'd0);
        else chk_eq("drain_data", {24'd0, if_dout}, {24'd0, q.pop_front()});
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_eq("drain_left", 32'(q.size()), 32'd0);
    chk_eq("drain_empty", {31'd0, if_empty_n}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
